// File: rtl/register_u_pkg.sv
// Shared types and constants for the universal register.
package register_u_pkg;

  localparam int MODE_W = 3;

  // Operation select. The encoding is fixed so software and tables can use raw values.
  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    INC  = 3'd6,
    DEC  = 3'd7
  } mode_t;

  // True for the two counting modes, the only ones that can wrap.
  function automatic logic is_count(input mode_t m);
    return (m == INC) || (m == DEC);
  endfunction

endpackage

// File: rtl/register_u_next.sv
// Combinational next-state datapath for register_u: computes the next register
// value, the wrap (terminal count) condition and the serial output from the
// current contents and the selected mode.
// Optional build macro: REGISTER_U_SAT_EN (counting saturates instead of wrapping).
module register_u_next
  import register_u_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q_i,
  input  mode_t        mode_i,
  input  logic [W-1:0] d_i,
  input  logic         sin_i,
  output logic [W-1:0] q_next_o,
  output logic         wrap_o,
  output logic         sout_o
);

  logic [W-1:0] shl_v;
  logic [W-1:0] shr_v;
  logic [W-1:0] rol_v;
  logic [W-1:0] ror_v;
  logic [W-1:0] inc_v;
  logic [W-1:0] dec_v;
  logic         all_ones;
  logic         all_zero;

  // A one-bit register has no "rest of q" to shift, so the shift/rotate
  // forms are built separately to avoid zero-width slices.
  if (W == 1) begin : g_w1
    assign shl_v = sin_i;
    assign shr_v = sin_i;
    assign rol_v = q_i;
    assign ror_v = q_i;
  end else begin : g_wn
    assign shl_v = {q_i[W-2:0], sin_i};
    assign shr_v = {sin_i, q_i[W-1:1]};
    assign rol_v = {q_i[W-2:0], q_i[W-1]};
    assign ror_v = {q_i[0], q_i[W-1:1]};
  end

  assign all_ones = &q_i;
  assign all_zero = ~|q_i;

  // Modulo-2^W arithmetic; the carry/borrow is reported through wrap_o only.
  assign inc_v = q_i + {{(W-1){1'b0}}, 1'b1};
  assign dec_v = q_i - {{(W-1){1'b0}}, 1'b1};

  // Terminal count: the counting step about to leave the representable range.
  always_comb begin
    wrap_o = 1'b0;
    if (mode_i == INC) wrap_o = all_ones;
    if (mode_i == DEC) wrap_o = all_zero;
  end

  // Next-value mux over all eight modes.
  always_comb begin
    q_next_o = q_i;
    unique case (mode_i)
      HOLD: q_next_o = q_i;
      LOAD: q_next_o = d_i;
      SHL:  q_next_o = shl_v;
      SHR:  q_next_o = shr_v;
      ROL:  q_next_o = rol_v;
      ROR:  q_next_o = ror_v;
`ifdef REGISTER_U_SAT_EN
      // Saturating build: a step that would wrap keeps the current value.
      INC:  q_next_o = all_ones ? q_i : inc_v;
      DEC:  q_next_o = all_zero ? q_i : dec_v;
`else
      INC:  q_next_o = inc_v;
      DEC:  q_next_o = dec_v;
`endif
      default: q_next_o = q_i;
    endcase
  end

  // Serial output: the bit that leaves q on this shift/rotate edge.
  always_comb begin
    sout_o = 1'b0;
    case (mode_i)
      SHL, ROL: sout_o = q_i[W-1];
      SHR, ROR: sout_o = q_i[0];
      default:  sout_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_u.sv
// Universal register: W-bit storage with load, shift, rotate and up/down count,
// serial in/out, a combinational terminal-count flag and a sticky overflow flag.
// Optional build macro: REGISTER_U_SAT_EN (INC/DEC saturate rather than wrap;
// ovf is still raised on the saturating edge).
module register_u
  import register_u_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  input  mode_t        mode,
  input  logic [W-1:0] d,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout,
  output logic         tc,
  output logic         ovf
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         ovf_q;
  logic         ovf_d;
  logic         wrap;

  register_u_next #(
    .W (W)
  ) u_next (
    .q_i      (q_q),
    .mode_i   (mode),
    .d_i      (d),
    .sin_i    (sin),
    .q_next_o (q_d),
    .wrap_o   (wrap),
    .sout_o   (sout)
  );

  // Overflow is sticky: set by any wrapping count step, cleared only by LOAD
  // (or reset). LOAD and a wrap can never coincide since modes are exclusive.
  always_comb begin
    ovf_d = ovf_q;
    if (mode == LOAD) begin
      ovf_d = 1'b0;
    end else if (is_count(mode) && wrap) begin
      ovf_d = 1'b1;
    end
  end

  // State registers: reset beats enable, enable beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RST_VAL;
      ovf_q <= 1'b0;
    end else if (enb) begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  // tc looks only at mode and q, so it is valid even while enb is low.
  assign tc  = wrap;
  assign q   = q_q;
  assign ovf = ovf_q;

endmodule
